// File: rtl/cv32e40p_obi_sram_bridge.sv
// OBI slave to single-port synchronous SRAM bridge with configurable grant wait states.
// Define CV32E40P_OBI_BRIDGE_ERR_EN to answer out-of-range addresses with error responses.
module cv32e40p_obi_sram_bridge #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned MEM_AW      = 14,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              obi_req_i,
  output logic              obi_gnt_o,
  input  logic [31:0]       obi_addr_i,
  input  logic              obi_we_i,
  input  logic [3:0]        obi_be_i,
  input  logic [31:0]       obi_wdata_i,
  output logic              obi_rvalid_o,
  output logic [31:0]       obi_rdata_o,
  output logic              obi_err_o,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic              mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2
  } state_e;

  localparam logic [3:0] WS = WAIT_STATES[3:0];

`ifdef CV32E40P_OBI_BRIDGE_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  // Offset lies inside the SRAM window when every bit above the byte range is clear.
  function automatic logic addr_in_range(input logic [31:0] off);
    logic [31:0] hi_mask;
    hi_mask = ~((32'd1 << (MEM_AW + 32'd2)) - 32'd1);
    return ((off & hi_mask) == 32'd0);
  endfunction

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        rsp_pending_q;
  logic        rsp_we_q;
  logic        rsp_err_q;

  logic [31:0] offset_s;
  logic        err_s;
  logic        ready_s;
  logic        gnt_s;
  logic        mem_req_s;

  assign offset_s = obi_addr_i - BASE_ADDR;
  assign err_s    = ERR_EN & ~addr_in_range(offset_s);
  // With no wait states the idle state is already eligible for grant.
  assign ready_s  = (WAIT_STATES == 0) || (state_q == S_READY);

  // Grant and SRAM strobe decode; erroring accesses bypass the SRAM entirely.
  always_comb begin
    gnt_s     = 1'b0;
    mem_req_s = 1'b0;
    if (rst_i) begin
      gnt_s     = 1'b0;
      mem_req_s = 1'b0;
    end else if (ready_s && obi_req_i) begin
      mem_req_s = ~err_s;
      gnt_s     = err_s | mem_gnt_i;
    end else begin
      gnt_s     = 1'b0;
      mem_req_s = 1'b0;
    end
  end

  // Wait-state FSM; the counter only restarts from IDLE, never on a withheld SRAM grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (obi_req_i && (WAIT_STATES != 0)) begin
            cnt_q   <= 4'd1;
            state_q <= (WS == 4'd1) ? S_READY : S_WAIT;
          end else begin
            cnt_q   <= 4'd0;
            state_q <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (!obi_req_i) begin
            cnt_q   <= 4'd0;
            state_q <= S_IDLE;
          end else begin
            cnt_q   <= cnt_q + 4'd1;
            state_q <= ((cnt_q + 4'd1) == WS) ? S_READY : S_WAIT;
          end
        end
        S_READY: begin
          if (gnt_s) begin
            cnt_q   <= 4'd0;
            state_q <= S_IDLE;
          end else begin
            cnt_q   <= cnt_q;
            state_q <= S_READY;
          end
        end
        default: begin
          cnt_q   <= 4'd0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Response tracker: one response slot, loaded on every grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_pending_q <= 1'b0;
      rsp_we_q      <= 1'b0;
      rsp_err_q     <= 1'b0;
    end else begin
      rsp_pending_q <= gnt_s;
      rsp_we_q      <= gnt_s & obi_we_i;
      rsp_err_q     <= gnt_s & err_s;
    end
  end

  assign obi_gnt_o    = gnt_s;
  assign mem_req_o    = mem_req_s;
  assign mem_we_o     = obi_we_i;
  assign mem_be_o     = obi_be_i;
  assign mem_wdata_o  = obi_wdata_i;
  assign mem_addr_o   = offset_s[MEM_AW+1:2];

  // Reset masks the response in the same cycle so a discarded access never shows rvalid.
  assign obi_rvalid_o = rsp_pending_q & ~rst_i;
  assign obi_rdata_o  = (rsp_pending_q && !rsp_we_q && !rsp_err_q && !rst_i) ? mem_rdata_i : 32'd0;
`ifdef CV32E40P_OBI_BRIDGE_ERR_EN
  assign obi_err_o    = rsp_err_q & ~rst_i;
`else
  assign obi_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_cv32e40p_obi_sram_bridge.sv
// Directed bench for cv32e40p_obi_sram_bridge: one bridge with 0 and one with 3 wait states,
// each backed by a simple bench-side SRAM.
module tb_cv32e40p_obi_sram_bridge;

`ifdef CV32E40P_OBI_BRIDGE_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        req0, req3;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        mem_gnt;

  logic        gnt0, rvalid0, err0, mem_req0, mem_we0;
  logic [31:0] rdata0, mem_wdata0, mem_rdata0;
  logic [13:0] mem_addr0;
  logic [3:0]  mem_be0;
  logic        gnt3, rvalid3, err3, mem_req3, mem_we3;
  logic [31:0] rdata3, mem_wdata3, mem_rdata3;
  logic [13:0] mem_addr3;
  logic [3:0]  mem_be3;

  logic [31:0] sram0 [16384];
  logic [31:0] sram3 [16384];

  int tests = 0;
  int fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cv32e40p_obi_sram_bridge #(.BASE_ADDR(32'h1000_0000), .MEM_AW(14), .WAIT_STATES(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .obi_req_i(req0), .obi_gnt_o(gnt0), .obi_addr_i(addr),
    .obi_we_i(we), .obi_be_i(be), .obi_wdata_i(wdata), .obi_rvalid_o(rvalid0),
    .obi_rdata_o(rdata0), .obi_err_o(err0), .mem_req_o(mem_req0), .mem_gnt_i(mem_gnt),
    .mem_we_o(mem_we0), .mem_addr_o(mem_addr0), .mem_be_o(mem_be0),
    .mem_wdata_o(mem_wdata0), .mem_rdata_i(mem_rdata0)
  );

  cv32e40p_obi_sram_bridge #(.BASE_ADDR(32'h1000_0000), .MEM_AW(14), .WAIT_STATES(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .obi_req_i(req3), .obi_gnt_o(gnt3), .obi_addr_i(addr),
    .obi_we_i(we), .obi_be_i(be), .obi_wdata_i(wdata), .obi_rvalid_o(rvalid3),
    .obi_rdata_o(rdata3), .obi_err_o(err3), .mem_req_o(mem_req3), .mem_gnt_i(mem_gnt),
    .mem_we_o(mem_we3), .mem_addr_o(mem_addr3), .mem_be_o(mem_be3),
    .mem_wdata_o(mem_wdata3), .mem_rdata_i(mem_rdata3)
  );

  // SRAM model behind the zero-wait bridge
  always @(posedge clk) begin
    if (mem_req0 && mem_gnt) begin
      if (mem_we0) begin
        for (int b = 0; b < 4; b++)
          if (mem_be0[b]) sram0[mem_addr0][8*b +: 8] <= mem_wdata0[8*b +: 8];
      end else begin
        mem_rdata0 <= sram0[mem_addr0];
      end
    end
  end

  // SRAM model behind the three-wait bridge
  always @(posedge clk) begin
    if (mem_req3 && mem_gnt) begin
      if (mem_we3) begin
        for (int b = 0; b < 4; b++)
          if (mem_be3[b]) sram3[mem_addr3][8*b +: 8] <= mem_wdata3[8*b +: 8];
      end else begin
        mem_rdata3 <= sram3[mem_addr3];
      end
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b1; req3 = 1'b1; addr = 32'd0; we = 1'b0;
    be = 4'h0; wdata = 32'd0; mem_gnt = 1'b1;
    repeat (2) @(posedge clk);
    sample();
    chk1("rst_gnt0", gnt0, 1'b0);
    chk1("rst_memreq0", mem_req0, 1'b0);
    chk1("rst_rvalid0", rvalid0, 1'b0);
    chk32("rst_rdata0", rdata0, 32'd0);
    chk1("rst_err0", err0, 1'b0);
    chk1("rst_gnt3", gnt3, 1'b0);
    chk1("rst_memreq3", mem_req3, 1'b0);
    chk1("rst_rvalid3", rvalid3, 1'b0);

    next_cycle(); rst = 1'b0; req0 = 1'b0; req3 = 1'b0;

    // single write then read-back, zero wait states
    next_cycle(); req0 = 1'b1; addr = 32'h1000_0010; we = 1'b1; be = 4'hF; wdata = 32'hDEAD_BEEF;
    sample();
    chk1("wr_gnt", gnt0, 1'b1);
    chk1("wr_memreq", mem_req0, 1'b1);
    chk32("wr_memaddr", 32'(mem_addr0), 32'd4);
    chk1("wr_memwe", mem_we0, 1'b1);
    chk32("wr_membe", 32'(mem_be0), 32'hF);
    chk32("wr_memwdata", mem_wdata0, 32'hDEAD_BEEF);
    chk1("wr_no_early_rvalid", rvalid0, 1'b0);
    next_cycle(); req0 = 1'b0; we = 1'b0;
    sample();
    chk1("wr_rvalid", rvalid0, 1'b1);
    chk32("wr_rdata", rdata0, 32'd0);
    chk1("wr_err", err0, 1'b0);
    next_cycle(); req0 = 1'b1;
    sample();
    chk1("rd_gnt", gnt0, 1'b1);
    chk1("rd_memwe", mem_we0, 1'b0);
    next_cycle(); req0 = 1'b0;
    sample();
    chk1("rd_rvalid", rvalid0, 1'b1);
    chk32("rd_rdata", rdata0, 32'hDEAD_BEEF);
    next_cycle();
    sample();
    chk1("rd_single_rvalid", rvalid0, 1'b0);

    // back-to-back: 8 writes, then 8 reads with req held high
    for (int i = 0; i < 8; i++) begin
      next_cycle(); req0 = 1'b1; we = 1'b1; be = 4'hF;
      addr = 32'h1000_0100 + 32'(4 * i); wdata = 32'h1111_0000 + 32'(i);
      sample();
      chk1("b2b_wr_gnt", gnt0, 1'b1);
      chk32("b2b_wr_addr", 32'(mem_addr0), 32'(64 + i));
      if (i > 0) chk1("b2b_wr_rvalid", rvalid0, 1'b1);
    end
    for (int i = 0; i < 8; i++) begin
      next_cycle(); req0 = 1'b1; we = 1'b0; addr = 32'h1000_0100 + 32'(4 * i);
      sample();
      chk1("b2b_rd_gnt", gnt0, 1'b1);
      chk1("b2b_rd_rvalid", rvalid0, 1'b1);
      if (i > 0) chk32("b2b_rd_rdata", rdata0, 32'h1111_0000 + 32'(i - 1));
      else chk32("b2b_wr_last_rdata", rdata0, 32'd0);
    end
    next_cycle(); req0 = 1'b0;
    sample();
    chk1("b2b_last_rvalid", rvalid0, 1'b1);
    chk32("b2b_last_rdata", rdata0, 32'h1111_0007);
    next_cycle();
    sample();
    chk1("b2b_idle_rvalid", rvalid0, 1'b0);

    // partial byte write 0101 over 0x1111_0000 -> 0x11FF_00FF
    next_cycle(); req0 = 1'b1; we = 1'b1; be = 4'b0101; addr = 32'h1000_0100; wdata = 32'hFFFF_FFFF;
    sample();
    chk32("be_pass", 32'(mem_be0), 32'h5);
    next_cycle(); we = 1'b0; be = 4'hF;
    sample();
    next_cycle(); req0 = 1'b0;
    sample();
    chk32("be_rdata", rdata0, 32'h11FF_00FF);

    // three wait states: write then immediate read
    next_cycle(); req3 = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h1000_0020; wdata = 32'hCAFE_F00D;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) next_cycle();
      sample();
      chk1("ws3_wr_gnt", gnt3, (k == 4));
      chk1("ws3_wr_memreq", mem_req3, (k == 4));
    end
    next_cycle(); we = 1'b0;
    sample();
    chk1("ws3_wr_rvalid", rvalid3, 1'b1);
    chk32("ws3_wr_rdata", rdata3, 32'd0);
    chk1("ws3_rd_gnt1", gnt3, 1'b0);
    for (int k = 2; k <= 4; k++) begin
      next_cycle();
      sample();
      chk1("ws3_rd_gnt", gnt3, (k == 4));
      chk1("ws3_rd_no_rvalid", rvalid3, 1'b0);
    end
    next_cycle(); req3 = 1'b0;
    sample();
    chk1("ws3_rd_rvalid", rvalid3, 1'b1);
    chk32("ws3_rd_rdata", rdata3, 32'hCAFE_F00D);

    // SRAM grant withheld 5 cycles once READY, three-wait bridge
    next_cycle(); req3 = 1'b1; we = 1'b0; addr = 32'h1000_0020; mem_gnt = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) next_cycle();
      sample();
      chk1("stall3_gnt", gnt3, 1'b0);
      chk1("stall3_memreq", mem_req3, (k >= 4));
    end
    next_cycle(); mem_gnt = 1'b1;
    sample();
    chk1("stall3_gnt_release", gnt3, 1'b1);
    next_cycle(); req3 = 1'b0;
    sample();
    chk1("stall3_rvalid", rvalid3, 1'b1);
    chk32("stall3_rdata", rdata3, 32'hCAFE_F00D);

    // SRAM grant withheld 5 cycles, zero-wait bridge
    next_cycle(); req0 = 1'b1; addr = 32'h1000_0010; mem_gnt = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) next_cycle();
      sample();
      chk1("stall0_gnt", gnt0, 1'b0);
      chk1("stall0_memreq", mem_req0, 1'b1);
      chk1("stall0_rvalid", rvalid0, 1'b0);
    end
    next_cycle(); mem_gnt = 1'b1;
    sample();
    chk1("stall0_gnt_release", gnt0, 1'b1);
    next_cycle(); req0 = 1'b0;
    sample();
    chk1("stall0_rvalid_after", rvalid0, 1'b1);
    chk32("stall0_rdata", rdata0, 32'hDEAD_BEEF);

    // reset pulsed in the cycle after a grant drops the response
    next_cycle(); req0 = 1'b1; addr = 32'h1000_0010;
    sample();
    chk1("rstmid_gnt", gnt0, 1'b1);
    next_cycle(); rst = 1'b1;
    sample();
    chk1("rstmid_rvalid", rvalid0, 1'b0);
    chk32("rstmid_rdata", rdata0, 32'd0);
    chk1("rstmid_err", err0, 1'b0);
    chk1("rstmid_gnt_low", gnt0, 1'b0);
    chk1("rstmid_memreq", mem_req0, 1'b0);
    next_cycle(); rst = 1'b0;
    sample();
    chk1("rstmid_discarded", rvalid0, 1'b0);
    chk1("rstmid_regnt", gnt0, 1'b1);
    next_cycle(); req0 = 1'b0;
    sample();
    chk1("rstmid_rvalid_after", rvalid0, 1'b1);
    chk32("rstmid_rdata_after", rdata0, 32'hDEAD_BEEF);

    // address window edges and out-of-range handling
    next_cycle(); req0 = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h1000_0000; wdata = 32'h0123_4567;
    sample();
    chk32("word0_addr", 32'(mem_addr0), 32'd0);
    next_cycle(); we = 1'b0; addr = 32'h2000_0000;
    sample();
    chk1("oor_gnt", gnt0, 1'b1);
    chk1("oor_memreq", mem_req0, ~ERR_EN);
    chk32("oor_wrap_addr", 32'(mem_addr0), 32'd0);
    next_cycle(); addr = 32'h1000_FFFC;
    sample();
    chk1("oor_rvalid", rvalid0, 1'b1);
    chk1("oor_err", err0, ERR_EN);
    chk32("oor_rdata", rdata0, ERR_EN ? 32'd0 : 32'h0123_4567);
    chk1("top_gnt", gnt0, 1'b1);
    chk1("top_memreq", mem_req0, 1'b1);
    chk32("top_addr", 32'(mem_addr0), 32'h3FFF);
    next_cycle(); addr = 32'h0FFF_FFFC;
    sample();
    chk1("top_err", err0, 1'b0);
    chk1("below_gnt", gnt0, 1'b1);
    chk1("below_memreq", mem_req0, ~ERR_EN);
    chk32("below_addr", 32'(mem_addr0), 32'h3FFF);
    next_cycle(); req0 = 1'b0;
    sample();
    chk1("below_rvalid", rvalid0, 1'b1);
    chk1("below_err", err0, ERR_EN);
    next_cycle();
    sample();
    chk1("end_rvalid", rvalid0, 1'b0);
    chk1("end_err", err0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
